// File: rtl/lfsr_seq_ctrl_if.sv
// rtl/lfsr_seq_ctrl_if.sv - host-side run request and status bundle for the LFSR sequencer
interface lfsr_seq_ctrl_if #(
   parameter int CNT_W = 8
) ();
   logic             start;
   logic             abort;
   logic [3:0]       seed;
   logic [CNT_W-1:0] steps;
   logic             busy;
   logic             done;
   logic [3:0]       result;
   logic             period_vld;
   logic [CNT_W-1:0] period;
   logic             err_seed;

   modport master (
      output start, abort, seed, steps,
      input  busy, done, result, period_vld, period, err_seed
   );

   modport slave (
      input  start, abort, seed, steps,
      output busy, done, result, period_vld, period, err_seed
   );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// rtl/lfsr_seq_ctrl.sv - loads an external 4-bit LFSR, clocks it a requested number of times,
// reports the final state and the first recurrence of the seed.
module lfsr_seq_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   lfsr_seq_ctrl_if.slave      host,
   output logic                lfsr_rst_o,
   output logic                lfsr_sel_o,
   output logic [3:0]          lfsr_seed_o,
   input  logic [3:0]          lfsr_state_i
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [3:0]       seed_q, seed_d;
   logic [3:0]       result_q, result_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             pvld_q, pvld_d;
   logic             err_q, err_d;
   logic             hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         seed_q   <= '0;
         result_q <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         period_q <= '0;
         pvld_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         seed_q   <= seed_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         pvld_q   <= pvld_d;
         err_q    <= err_d;
      end
   end

   // cnt_q equals the number of shifts already applied to the state now on lfsr_state_i
   assign hit = ((state_q == S_RUN) || (state_q == S_DONE)) &&
                (lfsr_state_i == seed_q) && (cnt_q != '0) && !pvld_q;

   always_comb begin
      state_d     = state_q;
      seed_d      = seed_q;
      result_d    = result_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      period_d    = period_q;
      pvld_d      = pvld_q;
      err_d       = 1'b0;
      lfsr_sel_o  = 1'b0;
      lfsr_seed_o = lfsr_state_i;

      if (hit) begin
         period_d = cnt_q;
         pvld_d   = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (host.start) begin
               if (host.seed != 4'h0) begin
                  seed_d  = host.seed;
                  rem_d   = host.steps;
                  cnt_d   = '0;
                  pvld_d  = 1'b0;
                  state_d = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (host.abort) begin
               state_d = S_IDLE;
            end else begin
               lfsr_seed_o = seed_q;
               state_d     = (rem_q == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            // an abort suppresses this edge's shift so the LFSR keeps its visible value
            if (host.abort) begin
               state_d = S_IDLE;
            end else begin
               lfsr_sel_o = 1'b1;
               rem_d      = rem_q - CNT_W'(1);
               cnt_d      = cnt_q + CNT_W'(1);
               if (rem_q == CNT_W'(1)) state_d = S_DONE;
            end
         end
         S_DONE: begin
            result_d = lfsr_state_i;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign host.busy       = (state_q == S_LOAD) || (state_q == S_RUN);
   assign host.done       = (state_q == S_DONE);
   assign host.result     = result_q;
   assign host.period_vld = pvld_q;
   assign host.period     = period_q;
   assign host.err_seed   = err_q;
   assign lfsr_rst_o      = rst;

endmodule
